// File: rtl/dram_port_arbiter.sv
// Two-port arbiter in front of the DRAM controller user interface: picks one requester, runs a
// single rd/wr enable/busy handshake against the controller and returns data with a one-cycle ack.
module dram_port_arbiter #(
    parameter int PRIO_MODE    = 0,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 1023
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [2:0]  p0_ctrl,
    output logic [31:0] p0_rdata,
    output logic        p0_ack,
    output logic        p0_err,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [2:0]  p1_ctrl,
    output logic [31:0] p1_rdata,
    output logic        p1_ack,
    output logic        p1_err,

    output logic        m_rd_en,
    output logic        m_wr_en,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [2:0]  m_ctrl,
    input  logic [31:0] m_rdata,
    input  logic        m_busy,

    output logic        grant
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACPT,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    // Timeout counter runs 0..TIMEOUT-1; the abort fires on the TIMEOUT-th cycle in a wait state.
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [31:0]   ERR_DATA   = 32'hDEAD_BEEF;

    state_t          state;
    state_t          next_state;
    logic            we_q;
    logic            err_q;
    logic [TW-1:0]   tmo_cnt;
    logic [SW-1:0]   starve_cnt;

    logic            any_req;
    logic            pick;
    logic            issue_go;
    logic            in_wait;
    logic            tmo_hit;
    logic            tmo_abort;
    logic            done_ok;

    // Arbitration: pick=1 selects port 1. In round-robin mode 'grant' doubles as the rr pointer.
    always_comb begin
        any_req = p0_req | p1_req;
        if (PRIO_MODE == 1) begin
            pick = p1_req & (~p0_req | (starve_cnt == STARVE_MAX));
        end else begin
            pick = p1_req & (~p0_req | ~grant);
        end
    end

    always_comb begin
        issue_go  = (state == S_IDLE) & any_req & ~m_busy;
        in_wait   = (state == S_WAIT_ACPT) | (state == S_WAIT_DONE);
        tmo_hit   = (tmo_cnt == TMO_MAX);
        done_ok   = (state == S_WAIT_DONE) & ~m_busy;
        tmo_abort = tmo_hit & (((state == S_WAIT_ACPT) & ~m_busy) |
                               ((state == S_WAIT_DONE) &  m_busy));
    end

    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (issue_go) begin
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                next_state = S_WAIT_ACPT;
            end
            S_WAIT_ACPT: begin
                if (m_busy) begin
                    next_state = S_WAIT_DONE;
                end else if (tmo_hit) begin
                    next_state = S_RESP;
                end
            end
            S_WAIT_DONE: begin
                if (!m_busy || tmo_hit) begin
                    next_state = S_RESP;
                end
            end
            S_RESP: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Transaction fields are captured only at grant time; port inputs are ignored otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant      <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_ctrl     <= '0;
            tmo_cnt    <= '0;
            starve_cnt <= '0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            if (issue_go) begin
                grant   <= pick;
                we_q    <= pick ? p1_we    : p0_we;
                m_addr  <= pick ? p1_addr  : p0_addr;
                m_wdata <= pick ? p1_wdata : p0_wdata;
                m_ctrl  <= pick ? p1_ctrl  : p0_ctrl;
                err_q   <= 1'b0;
            end

            if ((next_state != state) &&
                ((next_state == S_WAIT_ACPT) || (next_state == S_WAIT_DONE))) begin
                tmo_cnt <= '0;
            end else if (in_wait) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (tmo_abort) begin
                err_q <= 1'b1;
                if (grant) begin
                    p1_rdata <= ERR_DATA;
                end else begin
                    p0_rdata <= ERR_DATA;
                end
            end else if (done_ok && !we_q) begin
                if (grant) begin
                    p1_rdata <= m_rdata;
                end else begin
                    p0_rdata <= m_rdata;
                end
            end

            // Starvation guard only tracks consecutive port-0 wins while port 1 is waiting.
            if (PRIO_MODE == 1) begin
                if (!p1_req) begin
                    starve_cnt <= '0;
                end else if (issue_go) begin
                    starve_cnt <= pick ? '0 : starve_cnt + 1'b1;
                end
            end
        end
    end

    // Enables decode from state, so an async reset drops them immediately.
    always_comb begin
        m_rd_en = 1'b0;
        m_wr_en = 1'b0;
        p0_ack  = 1'b0;
        p1_ack  = 1'b0;
        if ((state == S_ISSUE) || (state == S_WAIT_ACPT)) begin
            m_rd_en = ~we_q;
            m_wr_en =  we_q;
        end
        if (state == S_RESP) begin
            p0_ack = ~grant;
            p1_ack =  grant;
        end
        p0_err = p0_ack & err_q;
        p1_err = p1_ack & err_q;
    end

endmodule
